// File: rtl/mvm_seq_ctrl_if.sv
// mvm_seq_ctrl_if
// Bundles the control/handshake signals between the MVM sequencing controller and its
// datapath (x memory, A memory, MAC, y memory) plus the input and output streams.
//   master : the controller side (drives s_ready, memory controls, MAC controls, m_valid,
//            overflow, busy; samples s_valid, mac_ovf, m_ready).
//   slave  : the datapath / stream side, directions reversed.
// Parameters:
//   K   : matrix/vector dimension (K >= 2)
//   AWX : x/y memory address width
//   AWA : A memory address width
interface mvm_seq_ctrl_if #(
   parameter int unsigned K   = 3,
   parameter int unsigned AWX = $clog2(K),
   parameter int unsigned AWA = $clog2(K * K)
);

   // Input word stream (data goes straight to the x/A memories)
   logic           s_valid;
   logic           s_ready;

   // x / A memory write controls, shared with the compute-phase read addresses
   logic           wr_en_x;
   logic [AWX-1:0] addr_x;
   logic           wr_en_a;
   logic [AWA-1:0] addr_a;

   // MAC controls and its overflow flag
   logic           mac_en;
   logic           mac_first;
   logic           mac_ovf;

   // y memory (single shared read/write port)
   logic           wr_en_y;
   logic [AWX-1:0] addr_y;

   // Output word stream (data is the y memory data_out)
   logic           m_valid;
   logic           m_ready;

   // Status
   logic           overflow;
   logic           busy;

   modport master (
      input  s_valid,
      output s_ready,
      output wr_en_x,
      output addr_x,
      output wr_en_a,
      output addr_a,
      output mac_en,
      output mac_first,
      input  mac_ovf,
      output wr_en_y,
      output addr_y,
      output m_valid,
      input  m_ready,
      output overflow,
      output busy
   );

   modport slave (
      output s_valid,
      input  s_ready,
      input  wr_en_x,
      input  addr_x,
      input  wr_en_a,
      input  addr_a,
      input  mac_en,
      input  mac_first,
      output mac_ovf,
      input  wr_en_y,
      input  addr_y,
      input  m_valid,
      output m_ready,
      input  overflow,
      input  busy
   );

endinterface

// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl
// Sequencing controller for a KxK matrix-vector multiply datapath. Loads K x-words then
// K*K A-words (row-major) from a valid/ready stream, runs K*K back-to-back MAC cycles with
// no bubbles between rows, writes each row result to the y memory, then streams
// y[0..K-1] out over a valid/ready handshake. One job at a time.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous reset, active-low; while low every output is forced to 0
//   bus   : mvm_seq_ctrl_if master modport (stream handshakes, memory/MAC controls,
//           overflow and busy status)
// Phases: LoadX -> LoadA -> Compute (K*K) -> Drain (2) -> Prep (1) -> Output -> LoadX.
module mvm_seq_ctrl #(
   parameter int unsigned K   = 3,
   parameter int unsigned AWX = $clog2(K),
   parameter int unsigned AWA = $clog2(K * K)
) (
   input logic            clk,
   input logic            reset,
   mvm_seq_ctrl_if.master bus
);

   localparam logic [AWA-1:0] LastX = AWA'(K - 1);
   localparam logic [AWA-1:0] LastA = AWA'(K * K - 1);
   localparam logic [AWX-1:0] LastJ = AWX'(K - 1);

   typedef enum logic [2:0] {
      StLoadX,
      StLoadA,
      StCompute,
      StDrain,
      StPrep,
      StOutput
   } state_e;

   state_e         state_q, state_d;

   // n is the single phase counter: load index, flat issue index (= i*K+j), drain
   // phase, and output index o, depending on state. It is cleared on every phase exit.
   logic [AWA-1:0] n_q, n_d;
   logic [AWX-1:0] i_q, i_d;
   logic [AWX-1:0] j_q, j_d;

   // Read stage: the issue stage delayed one cycle to match the registered memory reads.
   logic           rd_q;
   logic           rd_first_q;
   logic           rd_last_q;
   logic [AWX-1:0] rd_row_q;

   // y write stage: the cycle after a row's last read stage.
   logic           wy_q;
   logic [AWX-1:0] wy_row_q;

   logic           ovf_q, ovf_d;

   // Addresses hold their last driven value when no phase owns them.
   logic [AWX-1:0] addr_x_q, addr_x_c;
   logic [AWA-1:0] addr_a_q, addr_a_c;
   logic [AWX-1:0] addr_y_q, addr_y_c;

   logic           s_ready_c;
   logic           wr_en_x_c;
   logic           wr_en_a_c;
   logic           m_valid_c;
   logic           hs_in;
   logic           hs_out;

   // ---------------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      i_d       = i_q;
      j_d       = j_q;
      ovf_d     = ovf_q | (rd_q & bus.mac_ovf);
      s_ready_c = 1'b0;
      wr_en_x_c = 1'b0;
      wr_en_a_c = 1'b0;
      m_valid_c = 1'b0;
      hs_in     = 1'b0;
      hs_out    = 1'b0;
      addr_x_c  = addr_x_q;
      addr_a_c  = addr_a_q;
      addr_y_c  = addr_y_q;

      unique case (state_q)
         StLoadX: begin
            s_ready_c = 1'b1;
            hs_in     = bus.s_valid;
            wr_en_x_c = hs_in;
            addr_x_c  = n_q[AWX-1:0];
            if (hs_in) begin
               if (n_q == LastX) begin
                  n_d     = '0;
                  state_d = StLoadA;
               end else begin
                  n_d = n_q + 1'b1;
               end
            end
         end

         StLoadA: begin
            s_ready_c = 1'b1;
            hs_in     = bus.s_valid;
            wr_en_a_c = hs_in;
            addr_a_c  = n_q;
            if (hs_in) begin
               if (n_q == LastA) begin
                  n_d     = '0;
                  i_d     = '0;
                  j_d     = '0;
                  state_d = StCompute;
               end else begin
                  n_d = n_q + 1'b1;
               end
            end
         end

         StCompute: begin
            // Issue (i,j): x[j] and A[i*K+j] are read for use in the next cycle.
            addr_x_c = j_q;
            addr_a_c = n_q;
            if (n_q == LastA) begin
               n_d     = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = StDrain;
            end else begin
               n_d = n_q + 1'b1;
               if (j_q == LastJ) begin
                  j_d = '0;
                  i_d = i_q + 1'b1;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end

         StDrain: begin
            // Cycle 1: read stage of the final product. Cycle 2: write y[K-1].
            if (n_q[0]) begin
               n_d     = '0;
               state_d = StPrep;
            end else begin
               n_d = AWA'(1);
            end
         end

         StPrep: begin
            addr_y_c = '0;
            state_d  = StOutput;
         end

         StOutput: begin
            m_valid_c = 1'b1;
            hs_out    = bus.m_ready;
            // Look ahead on the handshake so data_out is already the next word.
            addr_y_c  = n_q[AWX-1:0] + AWX'(hs_out);
            if (hs_out) begin
               if (n_q == LastX) begin
                  n_d     = '0;
                  ovf_d   = 1'b0;
                  state_d = StLoadX;
               end else begin
                  n_d = n_q + 1'b1;
               end
            end
         end

         default: begin
            n_d     = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = StLoadX;
         end
      endcase

      // y writes only occur in Compute/Drain, where nothing else owns addr_y.
      if (wy_q) begin
         addr_y_c = wy_row_q;
      end
   end

   // ---------------------------------------------------------------------------------
   // State and pipeline registers
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StLoadX;
         n_q        <= '0;
         i_q        <= '0;
         j_q        <= '0;
         rd_q       <= 1'b0;
         rd_first_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_row_q   <= '0;
         wy_q       <= 1'b0;
         wy_row_q   <= '0;
         ovf_q      <= 1'b0;
         addr_x_q   <= '0;
         addr_a_q   <= '0;
         addr_y_q   <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         i_q        <= i_d;
         j_q        <= j_d;
         rd_q       <= (state_q == StCompute);
         rd_first_q <= (j_q == '0);
         rd_last_q  <= (j_q == LastJ);
         rd_row_q   <= i_q;
         // y memory samples the old accumulator on the same edge the next row loads it.
         wy_q       <= rd_q & rd_last_q;
         wy_row_q   <= rd_row_q;
         ovf_q      <= ovf_d;
         addr_x_q   <= addr_x_c;
         addr_a_q   <= addr_a_c;
         addr_y_q   <= addr_y_c;
      end
   end

   // ---------------------------------------------------------------------------------
   // Outputs: forced low combinationally while reset is held
   // ---------------------------------------------------------------------------------
   assign bus.s_ready   = reset & s_ready_c;
   assign bus.wr_en_x   = reset & wr_en_x_c;
   assign bus.addr_x    = reset ? addr_x_c : '0;
   assign bus.wr_en_a   = reset & wr_en_a_c;
   assign bus.addr_a    = reset ? addr_a_c : '0;
   assign bus.mac_en    = reset & rd_q;
   assign bus.mac_first = reset & rd_q & rd_first_q;
   assign bus.wr_en_y   = reset & wy_q;
   assign bus.addr_y    = reset ? addr_y_c : '0;
   assign bus.m_valid   = reset & m_valid_c;
   assign bus.overflow  = reset & ovf_q;
   assign bus.busy      = reset & (state_q != StLoadX);

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb_mvm_seq_ctrl
// Directed bench for mvm_seq_ctrl with K=3. Surrounds the controller with a behavioural
// datapath (x/A/y memories with registered reads, 16-bit signed MAC with overflow flag)
// and checks handshakes, addresses, MAC scheduling, y results and the overflow flag.
module tb_mvm_seq_ctrl;

   localparam int unsigned K = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mvm_seq_ctrl_if #(.K(K)) bus ();

   mvm_seq_ctrl #(.K(K)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural datapath
   logic signed [15:0] s_data;
   logic signed [15:0] x_mem [K];
   logic signed [15:0] a_mem [K*K];
   logic signed [15:0] y_mem [K];
   logic signed [15:0] x_rd, a_rd, f_q, y_out;
   int                 prod, acc;

   assign prod = int'(x_rd) * int'(a_rd);
   assign acc  = (bus.mac_first ? 0 : int'(f_q)) + prod;
   assign bus.mac_ovf = bus.mac_en & ((acc > 32767) | (acc < -32768));

   always @(posedge clk) begin
      if (bus.wr_en_x && int'(bus.addr_x) < K) x_mem[bus.addr_x] <= s_data;
      if (bus.wr_en_a && int'(bus.addr_a) < K*K) a_mem[bus.addr_a] <= s_data;
      if (int'(bus.addr_x) < K) x_rd <= x_mem[bus.addr_x];
      if (int'(bus.addr_a) < K*K) a_rd <= a_mem[bus.addr_a];
      if (bus.mac_en) f_q <= 16'(acc);
      if (bus.wr_en_y && int'(bus.addr_y) < K) y_mem[bus.addr_y] <= f_q;
      if (int'(bus.addr_y) < K) y_out <= y_mem[bus.addr_y];
   end

   // Current job stimulus and expected results
   logic signed [15:0] job_x [K];
   logic signed [15:0] job_a [K*K];
   int                 job_y [K];

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_job(input int max_gap);
      int gap;
      for (int w = 0; w < K + K*K; w++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            #1;
            check("gap_wr_en", {bus.wr_en_x, bus.wr_en_a}, 0);
            check("gap_s_ready", bus.s_ready, 1);
         end
         @(negedge clk);
         bus.s_valid = 1'b1;
         s_data = (w < K) ? job_x[w] : job_a[w-K];
         #1;
         check("load_s_ready", bus.s_ready, 1);
         check("load_busy", bus.busy, (w < K) ? 0 : 1);
         check("load_overflow", bus.overflow, 0);
         if (w < K) begin
            check("wr_en_x", bus.wr_en_x, 1);
            check("addr_x_load", bus.addr_x, w);
            check("wr_en_a_in_x", bus.wr_en_a, 0);
         end else begin
            check("wr_en_a", bus.wr_en_a, 1);
            check("addr_a_load", bus.addr_a, w - K);
            check("wr_en_x_in_a", bus.wr_en_x, 0);
         end
      end
   endtask

   // Runs the K*K+3 cycles after the last A handshake (L+1 .. L+K*K+3); s_valid is held
   // high with junk data to show it is ignored.
   task automatic compute_phase(input int ovf_from);
      logic en_exp, first_exp, wy_exp;
      for (int t = 1; t <= K*K + 3; t++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         s_data = 16'sh7777;
         #1;
         en_exp    = (t >= 2) && (t <= K*K + 1);
         first_exp = en_exp && (((t - 2) % K) == 0);
         wy_exp    = (t >= K + 2) && (t <= K*K + 2) && (((t - 2) % K) == 0);
         check("cmp_s_ready", bus.s_ready, 0);
         check("cmp_wr_en_xa", {bus.wr_en_x, bus.wr_en_a}, 0);
         check("cmp_busy", bus.busy, 1);
         check("cmp_m_valid", bus.m_valid, 0);
         check("mac_en", bus.mac_en, en_exp);
         check("mac_first", bus.mac_first, first_exp);
         check("wr_en_y", bus.wr_en_y, wy_exp);
         if (wy_exp) check("addr_y_write", bus.addr_y, (t - 2) / K - 1);
         if (t <= K*K) begin
            check("addr_x_issue", bus.addr_x, (t - 1) % K);
            check("addr_a_issue", bus.addr_a, t - 1);
         end
         if (t == K*K + 3) check("addr_y_prep", bus.addr_y, 0);
         check("cmp_overflow", bus.overflow, (ovf_from > 0 && t >= ovf_from) ? 1 : 0);
      end
   endtask

   task automatic output_phase(input bit rand_ready, input int exp_ovf);
      int o;
      int budget;
      o = 0;
      budget = 0;
      while (o < K && budget < 200) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
         bus.m_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
         #1;
         check("m_valid", bus.m_valid, 1);
         check("y_data", y_out, job_y[o]);
         check("addr_y_out", bus.addr_y, o + (bus.m_ready ? 1 : 0));
         check("out_overflow", bus.overflow, exp_ovf);
         check("out_s_ready", bus.s_ready, 0);
         if (bus.m_ready) o++;
         budget++;
      end
      if (o < K) check("output_timeout", o, K);
   endtask

   task automatic set_job(input int kind);
      case (kind)
         0: begin // x={1,2,3}, A=1..9
            job_x = '{16'sd1, 16'sd2, 16'sd3};
            for (int k = 0; k < K*K; k++) job_a[k] = 16'(k + 1);
            job_y = '{14, 32, 50};
         end
         1: begin // all 127: every row overflows and wraps
            job_x = '{16'sd127, 16'sd127, 16'sd127};
            for (int k = 0; k < K*K; k++) job_a[k] = 16'sd127;
            job_y = '{-17149, -17149, -17149};
         end
         2: begin // x={1,1,1}, A=identity
            job_x = '{16'sd1, 16'sd1, 16'sd1};
            for (int k = 0; k < K*K; k++) job_a[k] = (k % (K + 1) == 0) ? 16'sd1 : 16'sd0;
            job_y = '{1, 1, 1};
         end
         default: begin // x={2,0,-1}, A=1..9
            job_x = '{16'sd2, 16'sd0, -16'sd1};
            for (int k = 0; k < K*K; k++) job_a[k] = 16'(k + 1);
            job_y = '{-1, 2, 5};
         end
      endcase
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      s_data = '0;

      // Held in reset: everything low.
      repeat (3) @(negedge clk);
      bus.s_valid = 1'b1;
      #1;
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_wr_en_x", bus.wr_en_x, 0);
      check("rst_m_valid", bus.m_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      bus.s_valid = 1'b0;
      #1;
      check("post_rst_s_ready", bus.s_ready, 1);
      check("post_rst_busy", bus.busy, 0);

      // Job 1: continuous stream, m_ready always high.
      set_job(0);
      load_job(0);
      compute_phase(0);
      output_phase(1'b0, 0);

      // Job 2: same data, random s_valid gaps and random m_ready.
      load_job(2);
      compute_phase(0);
      output_phase(1'b1, 0);

      // Job 3: overflow on the first row's third accumulate, sticky through output.
      set_job(1);
      load_job(0);
      compute_phase(5);
      output_phase(1'b1, 1);

      // Job 4: aborted by a one-cycle reset pulse mid-compute.
      set_job(0);
      load_job(0);
      repeat (4) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_s_ready", bus.s_ready, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_mac", {bus.mac_en, bus.mac_first}, 0);
      check("abort_wr_en", {bus.wr_en_x, bus.wr_en_a, bus.wr_en_y}, 0);
      check("abort_m_valid", bus.m_valid, 0);
      check("abort_overflow", bus.overflow, 0);
      check("abort_addr", {bus.addr_x, bus.addr_a, bus.addr_y}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_next_s_ready", bus.s_ready, 1);
      check("abort_next_busy", bus.busy, 0);

      // Job 5: identity matrix after the abort.
      set_job(2);
      load_job(0);
      compute_phase(0);
      output_phase(1'b0, 0);

      // Job 6: back-to-back with job 5, negative values.
      set_job(3);
      load_job(0);
      compute_phase(0);
      output_phase(1'b1, 0);

      @(negedge clk);
      bus.m_ready = 1'b0;
      #1;
      check("final_s_ready", bus.s_ready, 1);
      check("final_busy", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Sequencing controller for the K×K matrix-vector multiply datapath: x memory, A memory, MAC, y memory. It accepts K x-words then K·K A-words (row-major) over a valid/ready input stream and drives the memory addresses and write enables. It schedules back-to-back MAC accumulation with no inter-row bubbles, then streams y[0..K-1] out over a valid/ready output handshake. One job at a time; the next load starts only after the last y word is accepted.

## Interface
- K, default 3: matrix/vector dimension, K ≥ 2.
- AWX, default $clog2(K): x/y address width (2 for K=3).
- AWA, default $clog2(K*K): A address width (4 for K=3).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (0 = reset), sampled on clk.
- s_valid  in  1  input word valid (data path goes directly to x/A memories).
- s_ready  out  1  controller accepts an input word this cycle.
- wr_en_x / addr_x  out  1 / AWX  x-memory write enable / address.
- wr_en_a / addr_a  out  1 / AWA  A-memory write enable / address.
- mac_en  out  1  MAC register updates this edge with the current product.
- mac_first  out  1  with mac_en: f <= product (load) instead of f + product.
- mac_ovf  in  1  MAC overflow flag for the current accumulate.
- wr_en_y / addr_y  out  1 / AWX  y-memory write enable / address (shared read/write port).
- m_valid  out  1  y-memory data_out holds a valid y word.
- m_ready  in  1  downstream accepts the word.
- overflow  out  1  sticky: some accumulate of the current job overflowed.
- busy  out  1  high in every state except LOAD_X.

## Operation
- States: LOAD_X → LOAD_A → COMPUTE → DRAIN → PREP → OUTPUT → LOAD_X.
- LOAD_X: s_ready=1. Each s_valid&s_ready cycle asserts wr_en_x with addr_x = load counter n (0..K-1). After handshake n=K-1 → LOAD_A, counter to 0.
- LOAD_A: s_ready=1, as above with wr_en_a, addr_a = 0..K·K-1. After the last handshake → COMPUTE. s_valid low: no write, counter holds.
- COMPUTE: exactly K·K cycles. Issue index (i,j), row i, column j, j fastest. Drives addr_x=j and addr_a=i·K+j. Memories have 1-cycle registered reads.
- Read stage is the issue stage delayed 1 cycle. In it: mac_en=1, mac_first=(j==0).
- wr_en_y=1 with addr_y=i in the cycle after row i's j=K-1 read stage. This coincides with row i+1's mac_first cycle; the y memory samples the old f on the same edge.
- DRAIN: 2 cycles. Cycle 1 is the read stage of (K-1,K-1). Cycle 2 writes y[K-1].
- PREP: 1 cycle, addr_y=0 presented for read.
- OUTPUT: out index o. addr_y = o + (m_valid & m_ready), combinational look-ahead, so data_out tracks with no bubble. m_valid=1 throughout OUTPUT. The handshake at o=K-1 → LOAD_X, o cleared.
- overflow: cleared on LOAD_X entry. OR-accumulates mac_ovf during mac_en cycles. Held through OUTPUT.
- Outside their states: wr_en_*, mac_en, mac_first, m_valid = 0. Addresses are don't-care but held stable.

## Timing
- While reset=0: all outputs 0, state→LOAD_X, all counters 0. Memory contents are untouched.
- First cycle after reset release: s_ready=1, busy=0.
- Reset mid-job, in any state: abort; the next job behaves exactly as after power-up.
- Last A handshake in cycle L → COMPUTE at L+1..L+K·K, DRAIN at L+K·K+1..+2, PREP at L+K·K+3, first m_valid at L+K·K+4 (L+13 for K=3).
- m_ready low: m_valid stays 1, addr_y and data_out stable indefinitely.
- s_valid is ignored outside LOAD states; s_ready=0 there. No back-pressure from the compute side.
- Counters wrap only by explicit clear on state exit. They never run past K-1 or K·K-1.

## Test plan
- K=3, reset then continuous s_valid with x={1,2,3}, A={1..9}, m_ready=1 → 12 handshakes, addr_x 0,1,2 then addr_a 0..8; y stream 14, 32, 50; first m_valid at L+13; overflow=0.
- Same data with random s_valid gaps and random m_ready → identical writes and outputs. data_out/m_valid stable while m_ready=0. No duplicated or skipped y.
- Check mac_first pattern 1,0,0,1,0,0,1,0,0 across the 9 mac_en cycles. wr_en_y at addr 0,1,2 on the cycles after each row's third mac_en.
- x={127,127,127}, A all 127 (row sum 48387 > 32767, mac_ovf asserted) → overflow=1 from the overflowing accumulate until LOAD_X entry. Cleared for the next job.
- Reset pulsed low for one cycle mid-COMPUTE → all outputs 0 that cycle, s_ready=1 next. A subsequent job with x={1,1,1}, A=identity gives y=1,1,1.
- Back-to-back jobs: after the third y handshake s_ready=1 the next cycle. The second job with x={2,0,-1}, A={1..9} gives -1, 2, 5.
